// File: rtl/commit_trace_buffer_if.sv
// rtl/commit_trace_buffer_if.sv - commit capture and trace readout signal bundle
interface commit_trace_buffer_if #(
    parameter int COMMIT_WIDTH = 2,
    parameter int PC_WIDTH     = 32
);
    logic [COMMIT_WIDTH-1:0]               cm_valid;
    logic [COMMIT_WIDTH-1:0][PC_WIDTH-1:0] cm_pc;
    logic                                  rd_valid;
    logic                                  rd_ready;
    logic [PC_WIDTH-1:0]                   rd_data;
    logic                                  rd_last;

    modport master (
        output cm_valid, cm_pc, rd_ready,
        input  rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cm_valid, cm_pc, rd_ready,
        output rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - circular commit PC recorder with trigger freeze and oldest-first readout
module commit_trace_buffer #(
    parameter int COMMIT_WIDTH = 2,
    parameter int PC_WIDTH     = 32,
    parameter int DEPTH        = 64,
    parameter int POST_TRIGGER = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_arm,
    input  logic                  i_trigger,
    commit_trace_buffer_if.slave  bus,
    output logic [1:0]            o_state,
    output logic                  o_wrapped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [PC_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_total, r_post_rem, r_read_rem;
    logic                r_wrapped, r_rd_valid, r_rd_last;
    logic [PC_WIDTH-1:0] r_rd_data;

    logic                    w_rec, w_load, w_done;
    logic [COMMIT_WIDTH-1:0] w_we;
    logic [AW-1:0]           w_off [COMMIT_WIDTH];
    logic [AW:0]             w_nwr, w_limit, w_post_left, w_tot_nxt;
    logic [AW+1:0]           w_tot_sum;
    logic [AW-1:0]           w_wr_nxt;

    // Compact valid slots in slot order; in POST only the first postRem of them are kept.
    always_comb begin
        w_rec   = !i_arm && (r_state == S_ARMED || r_state == S_POST);
        w_limit = (r_state == S_POST) ? r_post_rem : (AW+1)'(COMMIT_WIDTH);
        w_nwr   = '0;
        w_we    = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_off[i] = w_nwr[AW-1:0];
            w_we[i]  = w_rec && bus.cm_valid[i] && (w_nwr < w_limit);
            if (w_we[i]) w_nwr = w_nwr + (AW+1)'(1);
        end
        w_tot_sum   = {1'b0, r_total} + {1'b0, w_nwr};
        w_tot_nxt   = (w_tot_sum > DEPTH_W) ? DEPTH_W[AW:0] : w_tot_sum[AW:0];
        w_wr_nxt    = r_wr_ptr + w_nwr[AW-1:0];
        w_post_left = r_post_rem - w_nwr;
    end

    assign w_load = (r_state == S_FROZEN) &&
                    ((!r_rd_valid && r_read_rem != '0) || (r_rd_valid && bus.rd_ready && !r_rd_last));
    assign w_done = (r_state == S_FROZEN) &&
                    ((!r_rd_valid && r_read_rem == '0) || (r_rd_valid && bus.rd_ready && r_rd_last));

    always_comb begin
        w_state_nxt = r_state;
        if (i_arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED:  if (i_trigger) w_state_nxt = (POST_TRIGGER == 0) ? S_FROZEN : S_POST;
                S_POST:   if (w_post_left == '0) w_state_nxt = S_FROZEN;
                S_FROZEN: if (w_done) w_state_nxt = S_IDLE;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_WIDTH; i++)
            if (w_we[i]) r_mem[r_wr_ptr + w_off[i]] <= bus.cm_pc[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_total    <= '0;
            r_post_rem <= '0;
            r_read_rem <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
        end else if (i_arm) begin
            r_wr_ptr   <= '0;
            r_total    <= '0;
            r_wrapped  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            if (w_rec) begin
                r_wr_ptr <= w_wr_nxt;
                r_total  <= w_tot_nxt;
                if (w_tot_sum > DEPTH_W) r_wrapped <= 1'b1;
            end
            if (r_state == S_ARMED && i_trigger) r_post_rem <= (AW+1)'(POST_TRIGGER);
            if (r_state == S_POST)               r_post_rem <= w_post_left;
            // Oldest entry is computed from the post-write pointer and count on the freezing edge.
            if (r_state != S_FROZEN && w_state_nxt == S_FROZEN) begin
                r_rd_ptr   <= w_wr_nxt - w_tot_nxt[AW-1:0];
                r_read_rem <= w_tot_nxt;
            end
            if (w_load) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_valid <= 1'b1;
                r_rd_last  <= (r_read_rem == (AW+1)'(1));
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_read_rem <= r_read_rem - 1'b1;
            end else if (w_done) begin
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_last  = r_rd_last;
    assign o_state      = r_state;
    assign o_wrapped    = r_wrapped;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;
    localparam logic [1:0] IDL = 2'd0, ARM = 2'd1, PST = 2'd2, FRZ = 2'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, arm, trig, arm2, trig2;
    logic [1:0] st, st2;
    logic       wrp, wrp2;

    commit_trace_buffer_if #(.COMMIT_WIDTH(2), .PC_WIDTH(32)) bus ();
    commit_trace_buffer_if #(.COMMIT_WIDTH(2), .PC_WIDTH(32)) bus2 ();

    commit_trace_buffer #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .DEPTH(8), .POST_TRIGGER(4)) dut (
        .clk(clk), .rst(rst), .i_arm(arm), .i_trigger(trig),
        .bus(bus.slave), .o_state(st), .o_wrapped(wrp)
    );

    commit_trace_buffer #(.COMMIT_WIDTH(2), .PC_WIDTH(32), .DEPTH(8), .POST_TRIGGER(0)) dut0 (
        .clk(clk), .rst(rst), .i_arm(arm2), .i_trigger(trig2),
        .bus(bus2.slave), .o_state(st2), .o_wrapped(wrp2)
    );

    typedef struct {
        logic        arm;
        logic        trig;
        logic [1:0]  v;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  keep;
        logic [1:0]  st;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic a, input logic t, input logic [1:0] v,
                                input logic [31:0] p0, input logic [31:0] p1,
                                input logic [1:0] k, input logic [1:0] s);
        vq.push_back(vec_t'{a, t, v, p0, p1, k, s});
    endfunction

    // Apply each vector for one cycle; expected readout is pushed as commits are driven.
    task automatic run_vecs;
        for (int i = 0; i < vq.size(); i++) begin
            arm           = vq[i].arm;
            trig          = vq[i].trig;
            bus.cm_valid  = vq[i].v;
            bus.cm_pc[0]  = vq[i].pc0;
            bus.cm_pc[1]  = vq[i].pc1;
            if (vq[i].arm)     exp_q.delete();
            if (vq[i].keep[0]) exp_q.push_back(vq[i].pc0);
            if (vq[i].keep[1]) exp_q.push_back(vq[i].pc1);
            while (exp_q.size() > 8) void'(exp_q.pop_front());
            step();
            chk($sformatf("state_vec%0d", i), {30'd0, st}, {30'd0, vq[i].st});
        end
        arm = 1'b0; trig = 1'b0; bus.cm_valid = 2'b00;
        vq.delete();
    endtask

    task automatic drain(input bit bp, input int stop_after, input int exp_xfers);
        int xfers = 0;
        bit seen = 1'b0;
        bit bubble = 1'b0;
        logic rdy;
        for (int cyc = 0; cyc < 60; cyc++) begin
            rdy = bp ? (cyc % 3 == 0) : 1'b1;
            bus.rd_ready = rdy;
            if (bus.rd_valid) begin
                seen = 1'b1;
                if (exp_q.size() == 0) chk("rd_extra_entry", 32'd1, 32'd0);
                else begin
                    chk("rd_data", bus.rd_data, exp_q[0]);
                    chk("rd_last", {31'd0, bus.rd_last}, {31'd0, exp_q.size() == 1});
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        xfers++;
                    end
                end
            end else if (seen && st == FRZ) bubble = 1'b1;
            step();
            if (stop_after != 0 && xfers == stop_after) break;
            if (st == IDL) break;
        end
        bus.rd_ready = 1'b0;
        if (stop_after == 0) begin
            chk("xfer_count", xfers, exp_xfers);
            chk("end_state_idle", {30'd0, st}, {30'd0, IDL});
            chk("end_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
            if (!bp) chk("no_bubble", {31'd0, bubble}, 32'd0);
        end
    endtask

    task automatic scen1;
        add(1, 0, 2'b00, 0, 0, 2'b00, ARM);
        for (int i = 0; i < 3; i++) add(0, 0, 2'b01, 32'h100 + 4 * i, 0, 2'b01, ARM);
        add(0, 1, 2'b00, 0, 0, 2'b00, PST);
        for (int i = 0; i < 4; i++) add(0, 0, 2'b01, 32'h10C + 4 * i, 0, 2'b01, (i == 3) ? FRZ : PST);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; arm2 = 1'b0; trig2 = 1'b0;
        bus.cm_valid = 2'b00; bus.cm_pc[0] = '0; bus.cm_pc[1] = '0; bus.rd_ready = 1'b0;
        bus2.cm_valid = 2'b00; bus2.cm_pc[0] = '0; bus2.cm_pc[1] = '0; bus2.rd_ready = 1'b1;
        step(); step();
        chk("rst_state", {30'd0, st}, 32'd0);
        chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("rst_rd_last", {31'd0, bus.rd_last}, 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_wrapped", {31'd0, wrp}, 32'd0);
        rst = 1'b0;

        // No wrap
        scen1(); run_vecs();
        chk("s1_wrapped", {31'd0, wrp}, 32'd0);
        drain(1'b0, 0, 7);

        // Wrap-around keeps the newest eight
        add(1, 0, 2'b00, 0, 0, 2'b00, ARM);
        for (int i = 0; i < 12; i++) add(0, 0, 2'b01, 4 * i, 0, 2'b01, ARM);
        add(0, 1, 2'b00, 0, 0, 2'b00, PST);
        for (int i = 0; i < 4; i++) add(0, 0, 2'b01, 32'h30 + 4 * i, 0, 2'b01, (i == 3) ? FRZ : PST);
        run_vecs();
        chk("s2_wrapped", {31'd0, wrp}, 32'd1);
        drain(1'b0, 0, 8);

        // Dual-slot compaction, post-window drop
        add(1, 0, 2'b00, 0, 0, 2'b00, ARM);
        add(0, 0, 2'b10, 32'hDEAD, 32'hA0, 2'b10, ARM);
        add(0, 1, 2'b00, 0, 0, 2'b00, PST);
        add(0, 0, 2'b11, 32'hB0, 32'hB4, 2'b11, PST);
        add(0, 0, 2'b11, 32'hC0, 32'hC4, 2'b11, FRZ);
        add(0, 0, 2'b11, 32'hD0, 32'hD4, 2'b00, FRZ);
        run_vecs();
        drain(1'b0, 0, 5);

        // Backpressure
        scen1(); run_vecs();
        drain(1'b1, 0, 7);

        // Edge cases: trigger in IDLE, arm+trigger, trigger before any commit
        add(0, 1, 2'b00, 0, 0, 2'b00, IDL);
        add(1, 1, 2'b00, 0, 0, 2'b00, ARM);
        add(0, 1, 2'b00, 0, 0, 2'b00, PST);
        for (int i = 0; i < 4; i++) add(0, 0, 2'b01, 32'h300 + 4 * i, 0, 2'b01, (i == 3) ? FRZ : PST);
        run_vecs();
        drain(1'b0, 0, 4);

        // Zero-entry freeze on the POST_TRIGGER=0 instance
        arm2 = 1'b1; step(); arm2 = 1'b0;
        chk("z_armed", {30'd0, st2}, {30'd0, ARM});
        trig2 = 1'b1; step(); trig2 = 1'b0;
        chk("z_frozen", {30'd0, st2}, {30'd0, FRZ});
        chk("z_rd_valid0", {31'd0, bus2.rd_valid}, 32'd0);
        step();
        chk("z_idle", {30'd0, st2}, {30'd0, IDL});
        chk("z_rd_valid1", {31'd0, bus2.rd_valid}, 32'd0);
        step();
        chk("z_rd_valid2", {31'd0, bus2.rd_valid}, 32'd0);

        // Reset mid-read
        scen1(); run_vecs();
        drain(1'b0, 2, 0);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_state", {30'd0, st}, {30'd0, IDL});
        chk("midrst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
        chk("midrst_wrapped", {31'd0, wrp}, 32'd0);
        exp_q.delete();

        // Arm mid-read, then a fresh capture
        scen1(); run_vecs();
        drain(1'b0, 2, 0);
        add(1, 0, 2'b00, 0, 0, 2'b00, ARM);
        add(0, 0, 2'b01, 32'h200, 0, 2'b01, ARM);
        add(0, 1, 2'b00, 0, 0, 2'b00, PST);
        for (int i = 0; i < 4; i++) add(0, 0, 2'b01, 32'h204 + 4 * i, 0, 2'b01, (i == 3) ? FRZ : PST);
        run_vecs();
        drain(1'b0, 0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
